// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel/line counters, visible-area and strobe decodes,
// and hs/vs delayed through a short pipeline to line up with registered RGB.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       Reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(HS_FIRST);
  localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(HS_LAST);
  localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(VS_FIRST);
  localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(VS_LAST);

  logic             running;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic             hs_raw;
  logic             vs_raw;

  // running goes high one edge after Reset drops; counters hold at 0 for that edge
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      running <= 1'b0;
      hc      <= '0;
      vc      <= '0;
    end else begin
      running <= 1'b1;
      if (running) begin
        if (hc == H_MAX) begin
          hc <= '0;
          vc <= (vc == V_MAX) ? '0 : vc + CNT_W'(1);
        end else begin
          hc <= hc + CNT_W'(1);
        end
      end
    end
  end

  // Same-cycle decodes of the counters; everything idle while not running
  always_comb begin
    blank       = running && (hc < H_VIS_C) && (vc < V_VIS_C);
    line_start  = running && (hc == '0);
    frame_start = running && (hc == '0) && (vc == '0);
    hs_raw      = !(running && (hc >= HS_LO) && (hc <= HS_HI));
    vs_raw      = !(running && (vc >= VS_LO) && (vc <= VS_HI));
  end

  assign DrawX = hc;
  assign DrawY = vc;

  // Sync alignment pipeline; reset fills it with the idle level so no stale pulse escapes
  if (SYNC_DELAY == 0) begin : g_sync_direct
    assign hs = hs_raw;
    assign vs = vs_raw;
  end else if (SYNC_DELAY == 1) begin : g_sync_one
    logic hs_q;
    logic vs_q;
    always_ff @(posedge vga_clk) begin
      if (Reset) begin
        hs_q <= 1'b1;
        vs_q <= 1'b1;
      end else begin
        hs_q <= hs_raw;
        vs_q <= vs_raw;
      end
    end
    assign hs = hs_q;
    assign vs = vs_q;
  end else begin : g_sync_multi
    logic [SYNC_DELAY-1:0] hs_pipe;
    logic [SYNC_DELAY-1:0] vs_pipe;
    always_ff @(posedge vga_clk) begin
      if (Reset) begin
        hs_pipe <= '1;
        vs_pipe <= '1;
      end else begin
        hs_pipe <= {hs_pipe[SYNC_DELAY-2:0], hs_raw};
        vs_pipe <= {vs_pipe[SYNC_DELAY-2:0], vs_raw};
      end
    end
    assign hs = hs_pipe[SYNC_DELAY-1];
    assign vs = vs_pipe[SYNC_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing plus short-frame builds at sync delays 0/1/3.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  logic Reset;

  logic [9:0] ax, ay, bx, by, cx, cy, dx, dy;
  logic ab, ahs, avs, als, afs;
  logic bb, bhs, bvs, bls, bfs;
  logic cb, chs, cvs, cls, cfs;
  logic db, dhs, dvs, dls, dfs;

  int vectors = 0;
  int errors  = 0;
  int t       = 0;

  // Default 800x525 timing, one sync stage
  vga_timing_gen u_a (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(ax), .DrawY(ay), .blank(ab),
    .hs(ahs), .vs(avs), .line_start(als), .frame_start(afs));

  // Short frame (8 lines, vsync on lines 5..6) so whole frames fit the run
  vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(1)) u_b (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(bx), .DrawY(by), .blank(bb),
    .hs(bhs), .vs(bvs), .line_start(bls), .frame_start(bfs));

  vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(3)) u_c (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(cx), .DrawY(cy), .blank(cb),
    .hs(chs), .vs(cvs), .line_start(cls), .frame_start(cfs));

  vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(0)) u_d (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(dx), .DrawY(dy), .blank(db),
    .hs(dhs), .vs(dvs), .line_start(dls), .frame_start(dfs));

  // Expected hs for running-cycle index tt seen through d delay stages
  function automatic logic exp_hs(input int tt, input int d);
    int tp;
    tp = tt - d;
    if (tp < 0) return 1'b1;
    return !(((tp % 800) >= 656) && ((tp % 800) <= 751));
  endfunction

  function automatic logic exp_vs(input int tt, input int d, input int vtot, input int vfirst);
    int tp;
    int vcp;
    tp = tt - d;
    if (tp < 0) return 1'b1;
    vcp = (tp / 800) % vtot;
    return !((vcp == vfirst) || (vcp == vfirst + 1));
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    @(negedge vga_clk);
    t++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({ax, ay, ab, als, afs, ahs, avs} !== {10'd0, 10'd0, 5'b00011}) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got x=%0d y=%0d b/ls/fs/hs/vs=%b%b%b%b%b want x=0 y=0 00011",
                 i, ax, ay, ab, als, afs, ahs, avs);
      end
      vectors++;
      if ({chs, cvs, dhs, dvs} !== 4'b1111) begin
        errors++;
        $display("FAIL reset_sync[%0d]: got c hs/vs=%b%b d hs/vs=%b%b want 1111", i, chs, cvs, dhs, dvs);
      end
    end
    Reset = 1'b0;
    tick();
    t = 0;
    vectors++;
    if ({ax, ay, ab, als, afs, ahs, avs} !== {10'd0, 10'd0, 5'b11111}) begin
      errors++;
      $display("FAIL first_run: got x=%0d y=%0d b/ls/fs/hs/vs=%b%b%b%b%b want x=0 y=0 11111",
               ax, ay, ab, als, afs, ahs, avs);
    end
    tick();
    vectors++;
    if ({ax, ay, ab, als, afs} !== {10'd1, 10'd0, 3'b100}) begin
      errors++;
      $display("FAIL second_run: got x=%0d y=%0d b/ls/fs=%b%b%b want x=1 y=0 100", ax, ay, ab, als, afs);
    end
  endtask

  // Two lines of default timing: blank, strobes, hs edges and line period
  task automatic test_line();
    int hc, vca, hs_low, first_fall, first_rise, prev_ls;
    logic prev_hs;
    hs_low = 0; first_fall = -1; first_rise = -1; prev_ls = -1; prev_hs = 1'b1;
    while (t < 1601) begin
      tick();
      hc  = t % 800;
      vca = (t / 800) % 525;
      vectors++;
      if ({ax, ay, ab, als, afs, ahs, avs} !==
          {10'(hc), 10'(vca), (hc < 640) && (vca < 480), hc == 0, (hc == 0) && (vca == 0),
           exp_hs(t, 1), exp_vs(t, 1, 525, 490)}) begin
        errors++;
        $display("FAIL line_a t=%0d: got x=%0d y=%0d b/ls/fs/hs/vs=%b%b%b%b%b want x=%0d y=%0d",
                 t, ax, ay, ab, als, afs, ahs, avs, hc, vca);
      end
      vectors++;
      if ({dhs, chs} !== {exp_hs(t, 0), exp_hs(t, 3)}) begin
        errors++;
        $display("FAIL line_hs_delay t=%0d x=%0d: got d/c hs=%b%b want %b%b",
                 t, hc, dhs, chs, exp_hs(t, 0), exp_hs(t, 3));
      end
      if (t < 800) begin
        if (!ahs) hs_low++;
        if (prev_hs && !ahs && first_fall < 0) first_fall = int'(ax);
        if (!prev_hs && ahs && first_rise < 0) first_rise = int'(ax);
      end
      prev_hs = ahs;
      if (als) begin
        if (prev_ls >= 0) begin
          vectors++;
          if (t - prev_ls != 800) begin
            errors++;
            $display("FAIL line_period: got %0d want 800", t - prev_ls);
          end
        end
        prev_ls = t;
      end
    end
    vectors++;
    if (hs_low != 96) begin errors++; $display("FAIL hs_width: got %0d want 96", hs_low); end
    vectors++;
    if (first_fall != 657) begin errors++; $display("FAIL hs_fall_x: got %0d want 657", first_fall); end
    vectors++;
    if (first_rise != 753) begin errors++; $display("FAIL hs_rise_x: got %0d want 753", first_rise); end
    vectors++;
    if (prev_ls != 1600) begin errors++; $display("FAIL line_start_seen: got t=%0d want 1600", prev_ls); end
  endtask

  // Two short frames: vsync window, vertical blanking, frame period
  task automatic test_frames();
    int hc, vcb, vs_run, vs_pulses, prev_fs, fs_count, t_end;
    logic prev_vs;
    vs_run = 0; vs_pulses = 0; prev_fs = -1; fs_count = 0; prev_vs = 1'b1;
    t_end = t + 12800;
    while (t < t_end) begin
      tick();
      hc  = t % 800;
      vcb = (t / 800) % 8;
      vectors++;
      if ({bx, by, bb, bls, bfs, bhs, bvs} !==
          {10'(hc), 10'(vcb), (hc < 640) && (vcb < 4), hc == 0, (hc == 0) && (vcb == 0),
           exp_hs(t, 1), exp_vs(t, 1, 8, 5)}) begin
        errors++;
        $display("FAIL frame_b t=%0d: got x=%0d y=%0d b/ls/fs/hs/vs=%b%b%b%b%b want x=%0d y=%0d",
                 t, bx, by, bb, bls, bfs, bhs, bvs, hc, vcb);
      end
      vectors++;
      if ({dvs, cvs, avs} !== {exp_vs(t, 0, 8, 5), exp_vs(t, 3, 8, 5), 1'b1}) begin
        errors++;
        $display("FAIL frame_vs t=%0d: got d/c/a vs=%b%b%b want %b%b1",
                 t, dvs, cvs, avs, exp_vs(t, 0, 8, 5), exp_vs(t, 3, 8, 5));
      end
      if (!bvs) vs_run++;
      if (!prev_vs && bvs) begin
        vs_pulses++;
        vectors++;
        if (vs_run != 1600) begin errors++; $display("FAIL vs_width: got %0d want 1600", vs_run); end
        vs_run = 0;
      end
      prev_vs = bvs;
      if (bfs) begin
        fs_count++;
        if (prev_fs >= 0) begin
          vectors++;
          if (t - prev_fs != 6400) begin
            errors++;
            $display("FAIL frame_period: got %0d want 6400", t - prev_fs);
          end
        end
        prev_fs = t;
      end
    end
    vectors++;
    if (vs_pulses != 2) begin errors++; $display("FAIL vs_pulses: got %0d want 2", vs_pulses); end
    vectors++;
    if (fs_count != 2) begin errors++; $display("FAIL frame_starts: got %0d want 2", fs_count); end
  endtask

  // Simultaneous wrap of both counters
  task automatic test_wrap();
    while ((t % 6400) != 6399) tick();
    vectors++;
    if ({bx, by} !== {10'd799, 10'd7}) begin
      errors++;
      $display("FAIL wrap_pre: got x=%0d y=%0d want 799 7", bx, by);
    end
    tick();
    vectors++;
    if ({bx, by, bls, bfs, bb} !== {10'd0, 10'd0, 3'b111}) begin
      errors++;
      $display("FAIL wrap_post: got x=%0d y=%0d ls/fs/b=%b%b%b want 0 0 111", bx, by, bls, bfs, bb);
    end
    vectors++;
    if ({ax, ay, afs, als} !== {10'd0, 10'(((t / 800) % 525)), 2'b01}) begin
      errors++;
      $display("FAIL wrap_a: got x=%0d y=%0d fs/ls=%b%b want 0 %0d 01", ax, ay, afs, als, (t / 800) % 525);
    end
  endtask

  // Reset landing inside the hs low window with a 3-deep sync pipe
  task automatic test_mid_reset();
    int hs_low, first_fall;
    logic prev_hs;
    while ((t % 800) != 700) tick();
    vectors++;
    if ({cx, chs} !== {10'd700, 1'b0}) begin
      errors++;
      $display("FAIL pre_reset: got x=%0d hs=%b want 700 0", cx, chs);
    end
    Reset = 1'b1;
    tick();
    vectors++;
    if ({cx, cy, cb, cls, cfs, chs, cvs} !== {10'd0, 10'd0, 5'b00011}) begin
      errors++;
      $display("FAIL mid_reset: got x=%0d y=%0d b/ls/fs/hs/vs=%b%b%b%b%b want 0 0 00011",
               cx, cy, cb, cls, cfs, chs, cvs);
    end
    vectors++;
    if ({ahs, bhs, dhs, ax} !== {3'b111, 10'd0}) begin
      errors++;
      $display("FAIL mid_reset_others: got a/b/d hs=%b%b%b ax=%0d want 111 0", ahs, bhs, dhs, ax);
    end
    Reset = 1'b0;
    tick();
    t = 0;
    vectors++;
    if ({cx, cy, cb, cls, cfs, chs} !== {10'd0, 10'd0, 4'b1111}) begin
      errors++;
      $display("FAIL restart: got x=%0d y=%0d b/ls/fs/hs=%b%b%b%b want 0 0 1111", cx, cy, cb, cls, cfs, chs);
    end
    hs_low = 0; first_fall = -1; prev_hs = 1'b1;
    while (t < 799) begin
      tick();
      vectors++;
      if ({cx, chs} !== {10'(t), exp_hs(t, 3)}) begin
        errors++;
        $display("FAIL restart_line t=%0d: got x=%0d hs=%b want %0d %b", t, cx, chs, t, exp_hs(t, 3));
      end
      if (!chs) hs_low++;
      if (prev_hs && !chs && first_fall < 0) first_fall = int'(cx);
      prev_hs = chs;
    end
    vectors++;
    if (hs_low != 96) begin errors++; $display("FAIL restart_hs_width: got %0d want 96", hs_low); end
    vectors++;
    if (first_fall != 659) begin errors++; $display("FAIL restart_hs_fall: got %0d want 659", first_fall); end
  endtask

  initial begin
    Reset = 1'b1;
    test_reset();
    test_line();
    test_frames();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz display path. It counts pixel clocks into horizontal and vertical positions and drives DrawX/DrawY/blank to the sprite, background and palette stages downstream. It also produces hs/vs with a configurable pipeline delay, so that sync edges stay aligned with the registered RGB coming out of those stages. Frame and line strobes are provided for animation and game-state logic.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pipeline registers on hs/vs, legal 0..4

Ports:
- vga_clk  in  1  pixel clock (25 MHz nominal); all logic on posedge
- Reset  in  1  synchronous reset, active-high, sampled on posedge vga_clk
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = visible pixel (DrawX < H_VISIBLE and DrawY < V_VISIBLE), 0 = blanking
- hs  out  1  horizontal sync, active-low, delayed SYNC_DELAY clocks
- vs  out  1  vertical sync, active-low, delayed SYNC_DELAY clocks
- line_start  out  1  one-clock pulse when DrawX == 0
- frame_start  out  1  one-clock pulse when DrawX == 0 and DrawY == 0

## Operation
- H_TOTAL = sum of the H_* parameters (800 by default). V_TOTAL = sum of the V_* parameters (525 by default). Both must be ≤ 1024; DrawX/DrawY are the counter registers themselves.
- The running flag is a register. It is cleared by Reset and set on the first posedge with Reset low.
- Counters advance only while running = 1.
  - hc increments every clock and wraps H_TOTAL-1 -> 0.
  - vc increments when hc wraps, and wraps V_TOTAL-1 -> 0 on the same edge that hc wraps.
- blank, line_start and frame_start are combinational decodes of (hc, vc), ANDed with running. They are valid in the same cycle as DrawX/DrawY.
- Raw hsync is low for hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], which is 656..751 by default.
- Raw vsync is low for vc in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], which is 490..491 by default. It is asserted for whole lines, transitioning when hc wraps to 0.
- Both raw syncs are forced high while running = 0. They pass through a SYNC_DELAY-deep shift register to hs/vs. With SYNC_DELAY = 0, hs/vs equal the raw decode combinationally.
- Reset mid-frame:
  - The next edge with Reset high forces hc = vc = 0 and running = 0.
  - Every sync delay stage is set to 1.
  - No partial pulse is emitted afterwards.

## Timing
- Reset values (cycle after a Reset edge): DrawX = 0, DrawY = 0, blank = 0, line_start = 0, frame_start = 0, hs = 1, vs = 1.
- First posedge with Reset low: running goes to 1 and the counters hold at 0. That cycle shows blank = 1, line_start = 1, frame_start = 1.
- Each following posedge advances DrawX by 1.
- Latency from counter value to blank/strobes is 0 clocks. Latency from counter value to hs/vs is SYNC_DELAY clocks.
- With SYNC_DELAY = 1:
  - hs first falls in the cycle where DrawX = 657.
  - hs rises in the cycle where DrawX = 753.
- Line period is H_TOTAL clocks. Frame period is H_TOTAL*V_TOTAL clocks (420000 by default).
- frame_start recurs exactly every 420000 clocks. line_start recurs every 800 clocks, including during vertical blanking.
- Simultaneous wrap (hc = 799, vc = 524): the next cycle is hc = 0, vc = 0, with frame_start and line_start both high.
- Reset asserted during the hs low window: hs is 1 in the cycle after the Reset edge, regardless of SYNC_DELAY.

## Test plan
- Reset held 3 clocks, then released -> during reset DrawX = DrawY = 0, blank = 0, hs = vs = 1. The first cycle after release shows blank = 1 and frame_start = 1 with DrawX = 0; the next cycle shows DrawX = 1.
- Run one full line -> blank = 1 for DrawX 0..639 and 0 for 640..799. With SYNC_DELAY = 1, hs is low for exactly 96 clocks, starting when DrawX = 657. line_start pulses are 800 clocks apart.
- Run 2 full frames -> vs is low for exactly 1600 clocks, starting at DrawY = 490, DrawX = 0 (plus the delay). blank = 0 for all of DrawY 480..524. frame_start pulses are exactly 420000 clocks apart.
- Wrap corner -> at DrawX = 799, DrawY = 524, the next cycle is DrawX = 0, DrawY = 0 with frame_start = 1 and line_start = 1. No count of 800 or 525 ever appears.
- Reset asserted at DrawX = 700, DrawY = 100 (inside the hs low window) with SYNC_DELAY = 3 -> the next cycle shows hs = 1, DrawX = 0, blank = 0. After release, the timing restarts from the reset sequence.
- SYNC_DELAY = 0 build -> hs is low for DrawX 656..751 in the same cycle as the count, and all other checks still pass.
